// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the 7-segment scan controller.
package disp_pkg;

    localparam int NDIG = 4;
    localparam int IDX_W = 2;
    localparam logic [NDIG-1:0] AN_OFF = 4'hF;

    typedef logic [3:0] digit_t;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input digit_t nibble);
        return (nibble <= 4'd9);
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Slot prescaler: free-running DIV_W counter with a wrap tick and a guard window.
module disp_prescaler #(
    parameter int DIV_W = 16,
    parameter int GUARD = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o,
    output logic guard_o
);

    localparam logic [DIV_W-1:0] CNT_MAX = '1;
    localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);

    logic [DIV_W-1:0] r_cnt;

    // Counter wraps naturally from max back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o  = (r_cnt == CNT_MAX);
    assign guard_o = (r_cnt < GUARD_V);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with frame-synchronous value update,
// leading-zero suppression, invalid-digit blanking and an anode guard interval.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int GUARD    = 4,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] data_i,
    output logic        upd_ack_o,
    output logic        pend_o,
    output logic [3:0]  digit_o,
    output logic [3:0]  an_o,
    output logic        blank_o,
    output logic        frame_o,
    output logic        bcd_err_o
);

    logic             w_tick;
    logic             w_guard;
    logic             w_boundary;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_shadow;
    logic [15:0]      r_disp;
    logic             r_pend;
    logic             r_ack;
    digit_t           r_digit;
    logic [3:0]       r_an;
    logic             r_blank;

    digit_t           w_nib  [NDIG];
    logic [NDIG-1:0]  w_zero;
    logic [NDIG-1:0]  w_supp;
    logic [NDIG-1:0]  w_bad;
    logic             w_blank_now;

    disp_prescaler #(
        .DIV_W (DIV_W),
        .GUARD (GUARD)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_o  (w_tick),
        .guard_o (w_guard)
    );

    assign w_boundary = w_tick && (r_idx == IDX_W'(NDIG - 1));

    // Per-digit classification: zero, leading-zero suppressed, not decimal.
    // A digit is suppressed only if it and every more significant digit are zero.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
            assign w_nib[gi]  = r_disp[4*gi +: 4];
            assign w_zero[gi] = (w_nib[gi] == 4'd0);
            assign w_bad[gi]  = !is_bcd(w_nib[gi]);
            if (gi == 0) begin : g_ls
                assign w_supp[gi] = 1'b0;
            end else if (gi == NDIG - 1) begin : g_ms
                assign w_supp[gi] = LZ_BLANK && w_zero[gi];
            end else begin : g_mid
                assign w_supp[gi] = LZ_BLANK && w_zero[gi] && w_supp[gi+1];
            end
        end
    endgenerate

    assign w_blank_now = w_guard || w_supp[r_idx] || w_bad[r_idx];

    // Slot index, load handshake and frame-synchronous apply of the shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_pend   <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
            if (load_i) begin
                r_shadow <= data_i;
            end
            if (w_boundary) begin
                // A load landing on the boundary bypasses the shadow.
                if (load_i) begin
                    r_disp <= data_i;
                    r_pend <= 1'b0;
                    r_ack  <= 1'b1;
                end else if (r_pend) begin
                    r_disp <= r_shadow;
                    r_pend <= 1'b0;
                    r_ack  <= 1'b1;
                end
            end else if (load_i) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the slot index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
            r_an    <= AN_OFF;
            r_blank <= 1'b1;
        end else begin
            r_digit <= w_nib[r_idx];
            r_blank <= w_blank_now;
            r_an    <= w_blank_now ? AN_OFF : ~(4'b0001 << r_idx);
        end
    end

    assign upd_ack_o = r_ack;
    assign pend_o    = r_pend;
    assign digit_o   = r_digit;
    assign an_o      = r_an;
    assign blank_o   = r_blank;
    assign frame_o   = w_boundary;
    assign bcd_err_o = |w_bad;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with a 16-cycle slot and 64-cycle frame.
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [15:0] data_i;
    logic        upd_ack_o;
    logic        pend_o;
    logic [3:0]  digit_o;
    logic [3:0]  an_o;
    logic        blank_o;
    logic        frame_o;
    logic        bcd_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;

    disp_scan_ctrl #(
        .DIV_W    (4),
        .GUARD    (2),
        .LZ_BLANK (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_i),
        .data_i    (data_i),
        .upd_ack_o (upd_ack_o),
        .pend_o    (pend_o),
        .digit_o   (digit_o),
        .an_o      (an_o),
        .blank_o   (blank_o),
        .frame_o   (frame_o),
        .bcd_err_o (bcd_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally acknowledge pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n && upd_ack_o) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d);
        load_i = 1'b1;
        data_i = d;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    // Returns at the negedge where frame_o is high.
    task automatic wait_frame();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_o && t < 200);
        if (!frame_o) check("frame_timeout", 0, 1);
    endtask

    // Called one cycle after the boundary; checks guard and lit phases of each slot.
    task automatic scan(input string tag, input logic [15:0] v, input logic [15:0] exp_an);
        int j;
        logic [3:0] a;
        j = 1;
        for (int k = 0; k < 4; k++) begin
            a = exp_an[4*k +: 4];
            while (j < 16*k + 2) begin step(1); j++; end
            check({tag, "_guard_a_an"}, an_o, 4'hF);
            check({tag, "_guard_a_blank"}, blank_o, 1'b1);
            step(1); j++;
            check({tag, "_guard_b_an"}, an_o, 4'hF);
            step(1); j++;
            check({tag, "_slot_start_an"}, an_o, a);
            while (j < 16*k + 10) begin step(1); j++; end
            check({tag, "_an"}, an_o, a);
            check({tag, "_digit"}, digit_o, v[4*k +: 4]);
            check({tag, "_blank"}, blank_o, (a == 4'hF));
        end
    endtask

    // Full update: load mid-frame, expect one ack after the boundary, then scan.
    task automatic update(input string tag, input logic [15:0] v, input logic [15:0] exp_an);
        int a0;
        a0 = ack_cnt;
        do_load(v);
        check({tag, "_pend_set"}, pend_o, 1'b1);
        wait_frame();
        check({tag, "_pend_at_frame"}, pend_o, 1'b1);
        check({tag, "_no_early_ack"}, upd_ack_o, 1'b0);
        step(1);
        check({tag, "_ack"}, upd_ack_o, 1'b1);
        check({tag, "_pend_clr"}, pend_o, 1'b0);
        scan(tag, v, exp_an);
        check({tag, "_ack_count"}, ack_cnt - a0, 1);
    endtask

    initial begin
        int a0;
        int t;
        rst_n  = 1'b1;
        load_i = 1'b0;
        data_i = 16'h0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_an", an_o, 4'hF);
        check("rst_blank", blank_o, 1'b1);
        check("rst_digit", digit_o, 4'h0);
        check("rst_frame", frame_o, 1'b0);
        check("rst_ack", upd_ack_o, 1'b0);
        check("rst_err", bcd_err_o, 1'b0);
        check("rst_pend", pend_o, 1'b0);
        step(2);
        rst_n = 1'b1;

        // Reset mid-count with a value pending: discarded, no ack, idx restarts.
        step(40);
        do_load(16'h7777);
        check("midrst_pend_before", pend_o, 1'b1);
        step(3);
        a0 = ack_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_an", an_o, 4'hF);
        check("midrst_blank", blank_o, 1'b1);
        check("midrst_pend", pend_o, 1'b0);
        step(2);
        rst_n = 1'b1;
        t = 0;
        while (!frame_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("midrst_cycles_to_frame", t, 63);
        step(1);
        check("midrst_no_ack", upd_ack_o, 1'b0);
        check("midrst_ack_count", ack_cnt - a0, 0);
        step(20);

        update("v1234", 16'h1234, 16'h7BDE);

        // Two loads in one frame: only the last one is shown, single ack.
        a0 = ack_cnt;
        do_load(16'h1111);
        step(1);
        do_load(16'h5678);
        wait_frame();
        step(1);
        check("v5678_ack", upd_ack_o, 1'b1);
        scan("v5678", 16'h5678, 16'h7BDE);
        check("v5678_ack_count", ack_cnt - a0, 1);

        update("v0042", 16'h0042, 16'hFFDE);
        update("v0000", 16'h0000, 16'hFFFE);
        update("v12A4", 16'h12A4, 16'h7BFE);
        check("v12A4_err", bcd_err_o, 1'b1);

        // Error flag holds until the corrected value is applied.
        a0 = ack_cnt;
        do_load(16'h1204);
        wait_frame();
        check("v1204_err_before", bcd_err_o, 1'b1);
        step(1);
        check("v1204_err_after", bcd_err_o, 1'b0);
        scan("v1204", 16'h1204, 16'h7BDE);
        check("v1204_ack_count", ack_cnt - a0, 1);

        // Load coinciding with the boundary is applied directly.
        wait_frame();
        check("v9876_pend_before", pend_o, 1'b0);
        a0 = ack_cnt;
        load_i = 1'b1;
        data_i = 16'h9876;
        @(negedge clk);
        load_i = 1'b0;
        check("v9876_ack", upd_ack_o, 1'b1);
        check("v9876_pend", pend_o, 1'b0);
        scan("v9876", 16'h9876, 16'h7BDE);
        check("v9876_ack_count", ack_cnt - a0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
